// File: rtl/sobel_frame_ctrl_if.sv
// Pixel-stream / window / result bus between the Sobel frame controller and
// its surroundings.
//   pix_valid, pix_data, pix_ready : raster-order 8-bit pixel stream
//   win_valid, win_pix             : 3x3 window strobe and data to the PE chain
//   win_row, win_col               : window centre coordinates
//   res_valid                      : output_valid of the last PE stage
// master = pixel source / PE chain side, slave = frame controller side.
interface sobel_frame_ctrl_if;
  logic        pix_valid;
  logic [7:0]  pix_data;
  logic        pix_ready;
  logic        win_valid;
  logic [71:0] win_pix;
  logic [15:0] win_row;
  logic [15:0] win_col;
  logic        res_valid;

  modport master (
    output pix_valid, pix_data, res_valid,
    input  pix_ready, win_valid, win_pix, win_row, win_col
  );

  modport slave (
    input  pix_valid, pix_data, res_valid,
    output pix_ready, win_valid, win_pix, win_row, win_col
  );
endinterface

// File: rtl/sobel_frame_ctrl.sv
// Frame-level controller for the Sobel datapath. Buffers two image lines,
// issues one 3x3 window per interior pixel and signals end of frame once
// every issued window has returned a result from the PE chain.
//   clk, rst   : clock, asynchronous active-high reset
//   start      : one-cycle frame start, honoured only in IDLE
//   bus        : pixel stream in, window out, PE result strobe in
//   busy       : high in every state except IDLE
//   frame_done : one-cycle end-of-frame pulse
module sobel_frame_ctrl #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  sobel_frame_ctrl_if.slave   bus,
  output logic                busy,
  output logic                frame_done
);

  localparam int          CW       = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [15:0] LAST_COL = 16'(IMG_W - 1);
  localparam logic [15:0] LAST_ROW = 16'(IMG_H - 1);
  localparam logic [23:0] EXP_RES  = 24'((IMG_W - 2) * (IMG_H - 2));

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t      state, state_next;
  logic [15:0] row, col;
  logic [23:0] issued, returned;

  logic        pix_ready_r, win_valid_r, busy_r, frame_done_r;
  logic [71:0] win_pix_r, win_next;
  logic [15:0] win_row_r, win_col_r;

  logic [7:0]  lb_r1 [IMG_W];   // row r-1
  logic [7:0]  lb_r2 [IMG_W];   // row r-2
  logic [7:0]  sr [3][3];       // sr[i][2] is the newest column
  logic [7:0]  col_in [3];

  logic accept, last_pix, win_hit, res_count, all_returned;

  assign accept    = bus.pix_valid & pix_ready_r;
  assign last_pix  = accept && (row == LAST_ROW) && (col == LAST_COL);
  assign win_hit   = accept && (row >= 16'd2) && (col >= 16'd2);
  // Results only count while a frame is in flight, and saturate at the total.
  assign res_count = bus.res_valid && ((state == STREAM) || (state == DRAIN))
                     && (returned < EXP_RES);
  // A result arriving in the same cycle already counts towards completion.
  assign all_returned = (issued == EXP_RES) &&
                        ((returned == EXP_RES) ||
                         (res_count && (returned == EXP_RES - 24'd1)));

  assign col_in[0] = lb_r2[col[CW-1:0]];
  assign col_in[1] = lb_r1[col[CW-1:0]];
  assign col_in[2] = bus.pix_data;

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = STREAM; else state_next = IDLE;
      STREAM:  if (last_pix) state_next = DRAIN; else state_next = STREAM;
      DRAIN:   if (all_returned) state_next = DONE; else state_next = DRAIN;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Window assembled from the two older shift-register columns plus the
  // column arriving with this pixel.
  always_comb begin
    win_next = 72'd0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        win_next[8*(3*i+j) +: 8] = (j == 2) ? col_in[i] : sr[i][j+1];
      end
    end
  end

  // State register and state-derived registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      pix_ready_r  <= 1'b0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      state        <= state_next;
      pix_ready_r  <= (state_next == STREAM);
      busy_r       <= (state_next != IDLE);
      frame_done_r <= (state_next == DONE);
    end
  end

  // Raster position and issued/returned counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row      <= 16'd0;
      col      <= 16'd0;
      issued   <= 24'd0;
      returned <= 24'd0;
    end else if ((state == IDLE) && start) begin
      row      <= 16'd0;
      col      <= 16'd0;
      issued   <= 24'd0;
      returned <= 24'd0;
    end else begin
      if (accept) begin
        if (col == LAST_COL) begin
          col <= 16'd0;
          row <= (row == LAST_ROW) ? 16'd0 : row + 16'd1;
        end else begin
          col <= col + 16'd1;
        end
      end
      if (win_hit) begin
        issued <= issued + 24'd1;
      end
      if (res_count) begin
        returned <= returned + 24'd1;
      end
    end
  end

  // Line buffers: contents need no reset, every row is written before use
  always_ff @(posedge clk) begin
    if (accept) begin
      lb_r2[col[CW-1:0]] <= col_in[1];
      lb_r1[col[CW-1:0]] <= bus.pix_data;
    end
  end

  // Column shift registers and the registered window outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          sr[i][j] <= 8'd0;
        end
      end
      win_valid_r <= 1'b0;
      win_pix_r   <= 72'd0;
      win_row_r   <= 16'd0;
      win_col_r   <= 16'd0;
    end else begin
      win_valid_r <= win_hit;
      if (accept) begin
        for (int i = 0; i < 3; i++) begin
          sr[i][0] <= sr[i][1];
          sr[i][1] <= sr[i][2];
          sr[i][2] <= col_in[i];
        end
      end
      if (win_hit) begin
        win_pix_r <= win_next;
        win_row_r <= row - 16'd1;
        win_col_r <= col - 16'd1;
      end
    end
  end

  assign bus.pix_ready = pix_ready_r;
  assign bus.win_valid = win_valid_r;
  assign bus.win_pix   = win_pix_r;
  assign bus.win_row   = win_row_r;
  assign bus.win_col   = win_col_r;
  assign busy          = busy_r;
  assign frame_done    = frame_done_r;

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Self-checking bench for sobel_frame_ctrl: a 4x4 and a 3x3 instance share
// the stimulus; sel3 picks which one is started and observed.
module tb_sobel_frame_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start_d, sel3, pv, rv;
  logic [7:0] pd;
  logic       start4, start3, busy4, busy3, fd4, fd3;

  sobel_frame_ctrl_if bus4 ();
  sobel_frame_ctrl_if bus3 ();

  assign bus4.pix_valid = pv;
  assign bus4.pix_data  = pd;
  assign bus4.res_valid = rv;
  assign bus3.pix_valid = pv;
  assign bus3.pix_data  = pd;
  assign bus3.res_valid = rv;
  assign start4 = start_d & ~sel3;
  assign start3 = start_d & sel3;

  sobel_frame_ctrl #(.IMG_W(4), .IMG_H(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .bus(bus4.slave),
    .busy(busy4), .frame_done(fd4)
  );

  sobel_frame_ctrl #(.IMG_W(3), .IMG_H(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .bus(bus3.slave),
    .busy(busy3), .frame_done(fd3)
  );

  logic        s_pr, s_wv, s_busy, s_fd;
  logic [71:0] s_pix;
  logic [15:0] s_row, s_col;
  assign s_pr   = sel3 ? bus3.pix_ready : bus4.pix_ready;
  assign s_wv   = sel3 ? bus3.win_valid : bus4.win_valid;
  assign s_pix  = sel3 ? bus3.win_pix   : bus4.win_pix;
  assign s_row  = sel3 ? bus3.win_row   : bus4.win_row;
  assign s_col  = sel3 ? bus3.win_col   : bus4.win_col;
  assign s_busy = sel3 ? busy3          : busy4;
  assign s_fd   = sel3 ? fd3            : fd4;

  int checks   = 0;
  int failures = 0;
  logic [71:0] first_pix;

  task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected window around centre (r,c) for a frame whose pixel (y,x) = base + y*w + x.
  function automatic logic [71:0] exp_win(input int r, input int c, input int w, input int base);
    logic [71:0] v;
    v = 72'd0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        v[8*(3*i+j) +: 8] = 8'(base + (r - 1 + i) * w + (c - 1 + j));
    return v;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_pr"},   72'(s_pr),   72'd0);
    check_eq({tag, "_wv"},   72'(s_wv),   72'd0);
    check_eq({tag, "_pix"},  s_pix,       72'd0);
    check_eq({tag, "_row"},  72'(s_row),  72'd0);
    check_eq({tag, "_col"},  72'(s_col),  72'd0);
    check_eq({tag, "_busy"}, 72'(s_busy), 72'd0);
    check_eq({tag, "_fd"},   72'(s_fd),   72'd0);
  endtask

  // Runs one frame; res_valid follows win_valid by 3 cycles, plus optional extras.
  task automatic run_frame(input int w, input int h, input int base, input bit toggle,
                           input bit start_mid, input bit start_done, input int extra_res);
    int acc = 0, nwin = 0, res_sent = 0, fd_n = 0, cyc = 0, post = 0;
    int res_last = -10, exp_r = 0, exp_c = 0, extra_left = extra_res;
    int e = (w - 2) * (h - 2);
    logic [2:0] pipe = 3'd0;
    bit exp_wv = 1'b0, exp_drop = 1'b0, prev_wv = 1'b0, consec = 1'b0;
    bit done = 1'b0, mid_done = 1'b0;

    @(negedge clk);
    pv = 1'b0; rv = 1'b0; start_d = 1'b1;
    @(negedge clk);
    start_d = 1'b0;
    check_eq("pr_rise",   72'(s_pr),   72'd1);
    check_eq("busy_rise", 72'(s_busy), 72'd1);

    for (int k = 0; k < 300 && !done; k++) begin
      start_d = 1'b0;
      check_eq("win_valid", 72'(s_wv), 72'(exp_wv));
      if (s_wv) begin
        check_eq("win_pix", s_pix, exp_win(exp_r, exp_c, w, base));
        check_eq("win_row", 72'(s_row), 72'(exp_r));
        check_eq("win_col", 72'(s_col), 72'(exp_c));
        if (nwin == 0) first_pix = s_pix;
        if (prev_wv) consec = 1'b1;
        nwin++;
      end
      prev_wv = s_wv;
      if (exp_drop) begin
        check_eq("pr_drop", 72'(s_pr), 72'd0);
        exp_drop = 1'b0;
      end
      if (post > 0) begin
        check_eq("busy_after", 72'(s_busy), 72'd0);
        check_eq("fd_pulse",   72'(s_fd),   72'd0);
        post++;
        if (post > 3) done = 1'b1;
      end else if (s_fd) begin
        fd_n++;
        check_eq("fd_timing", 72'(cyc), 72'(res_last + 1));
        if (start_done) start_d = 1'b1;
        post = 1;
      end
      // result strobe from the delayed window strobe
      rv = pipe[2];
      pipe = {pipe[1:0], s_wv};
      if (rv) begin
        res_sent++;
        if (res_sent == e) res_last = cyc;
      end else if (extra_left > 0 && res_sent >= e) begin
        rv = 1'b1;
        extra_left--;
      end
      // pixel drive
      exp_wv = 1'b0;
      if (s_pr && acc < w * h && (!toggle || (k % 2) == 0)) begin
        pv = 1'b1;
        pd = 8'(base + acc);
        if (acc / w >= 2 && acc % w >= 2) begin
          exp_wv = 1'b1;
          exp_r = acc / w - 1;
          exp_c = acc % w - 1;
        end
        if (acc == w * h - 1) exp_drop = 1'b1;
        acc++;
      end else begin
        pv = 1'b0;
      end
      if (start_mid && acc == 5 && !mid_done) begin
        start_d = 1'b1;
        mid_done = 1'b1;
      end
      cyc++;
      @(negedge clk);
    end
    pv = 1'b0; rv = 1'b0; start_d = 1'b0;
    check_eq("frame_end_seen", 72'(done), 72'd1);
    check_eq("fd_count",  72'(fd_n), 72'd1);
    check_eq("win_count", 72'(nwin), 72'(e));
    check_eq("acc_count", 72'(acc),  72'(w * h));
    if (toggle) check_eq("no_consec_wv", 72'(consec), 72'd0);
  endtask

  initial begin
    int acc;
    rst = 1'b1; start_d = 1'b0; sel3 = 1'b0; pv = 1'b0; pd = 8'd0; rv = 1'b0;
    first_pix = 72'd0;
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("rst0");
    rst = 1'b0;

    // 4x4 continuous
    run_frame(4, 4, 0, 1'b0, 1'b0, 1'b0, 0);
    check_eq("first_win", first_pix,
             {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0});
    // 4x4 with pix_valid every other cycle
    run_frame(4, 4, 0, 1'b1, 1'b0, 1'b0, 0);
    // 3x3 minimum frame
    sel3 = 1'b1;
    run_frame(3, 3, 10, 1'b0, 1'b0, 1'b0, 0);
    check_eq("win3x3", first_pix,
             {8'd18, 8'd17, 8'd16, 8'd15, 8'd14, 8'd13, 8'd12, 8'd11, 8'd10});
    sel3 = 1'b0;
    // start mid-STREAM and in DONE, then a fresh frame
    run_frame(4, 4, 0, 1'b0, 1'b1, 1'b1, 0);
    run_frame(4, 4, 0, 1'b0, 1'b0, 1'b0, 0);

    // reset after 7 pixels, then stray results
    @(negedge clk);
    start_d = 1'b1;
    @(negedge clk);
    start_d = 1'b0;
    acc = 0;
    for (int k = 0; k < 50 && acc < 7; k++) begin
      pv = s_pr;
      pd = 8'(acc);
      if (s_pr) acc++;
      @(negedge clk);
    end
    pv = 1'b0;
    check_eq("pre_rst_busy", 72'(s_busy), 72'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      rv = (k == 1 || k == 3);
      @(negedge clk);
      check_eq("idle_busy", 72'(s_busy), 72'd0);
      check_eq("idle_fd",   72'(s_fd),   72'd0);
      check_eq("idle_pr",   72'(s_pr),   72'd0);
    end
    rv = 1'b0;
    run_frame(4, 4, 0, 1'b0, 1'b0, 1'b0, 0);

    // six results for four windows
    run_frame(4, 4, 0, 1'b0, 1'b0, 1'b0, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sobel_frame_ctrl.md
# sobel_frame_ctrl

Frame-level controller for the Sobel datapath. It accepts a raster-order 8-bit pixel stream, buffers two image lines, and issues one complete 3x3 window per interior pixel, with a `win_valid` strobe that drives `compute_valid` of the first PE stage in the Sobel chain. It then counts the `output_valid` results returned by the last PE stage and signals end of frame once every issued window has produced a result.

## Interface
- `IMG_W`, 64: image width in pixels; legal range 3..4096.
- `IMG_H`, 64: image height in lines; legal range 3..4096.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse that begins a frame; honoured only in IDLE.
- `pix_valid` in 1: input pixel valid.
- `pix_data` in 8: input pixel, unsigned, raster order.
- `pix_ready` out 1: controller accepts a pixel this cycle.
- `win_valid` out 1: window valid; connects to the PE chain `compute_valid`.
- `win_pix` out 72: 3x3 window; `win_pix[8*(3*i+j) +: 8]` = pixel(row r-2+i, col c-2+j), i = row offset, j = column offset.
- `win_row` out 16: window centre row (r-1).
- `win_col` out 16: window centre column (c-1).
- `res_valid` in 1: last PE stage `output_valid`.
- `busy` out 1: high in every state except IDLE.
- `frame_done` out 1: one-cycle pulse at end of frame.

## Operation
- Pixel (r,c) is accepted on a clock edge where `pix_valid && pix_ready`. Counters `col` (0..IMG_W-1) and `row` (0..IMG_H-1) advance only on acceptance. `col` wraps to 0 and increments `row` after IMG_W-1.
- Line buffers: two IMG_W x 8 memories hold rows r-1 and r-2, indexed by `col`. On acceptance:
  - read both memories at `col`;
  - write the row r-1 value into the r-2 memory;
  - write `pix_data` into the r-1 memory.
- Shift registers: three 3-deep column shift registers (one per window row) shift in {row r-2, row r-1, `pix_data`} on acceptance.
- A window is issued on acceptance of pixel (r,c) when r>=2 and c>=2. At the wrap to a new row, the shift registers need no flush, because no window is issued until c>=2.
- Line buffer contents are never reset. Rows are always written before they are read for an issued window.
- States:
  - IDLE: `pix_ready`=0. `start` → STREAM; clears `row`, `col`, `issued`, `returned`.
  - STREAM: `pix_ready`=1. Acceptance of pixel (IMG_H-1, IMG_W-1) → DRAIN.
  - DRAIN: `pix_ready`=0. Moves to DONE when `returned` reaches (IMG_W-2)*(IMG_H-2), counting a `res_valid` that arrives in the same cycle.
  - DONE: `frame_done`=1 for exactly one cycle, then IDLE.
- `issued` counts windows issued; `returned` counts `res_valid` pulses in STREAM and DRAIN.
- `res_valid` is ignored in IDLE and DONE.
- `returned` saturates at the expected count; extra pulses are ignored.
- `start` outside IDLE is ignored, including a `start` in the DONE cycle.
- `pix_valid` in IDLE, DRAIN or DONE is not accepted: `pix_ready` is low.
- `rst` asserted mid-frame:
  - state returns to IDLE, all counters clear, all outputs go to reset values;
  - in-flight PE results arriving afterwards are ignored.

## Timing
- Reset values: `pix_ready`=0, `win_valid`=0, `win_pix`=0, `win_row`=0, `win_col`=0, `busy`=0, `frame_done`=0.
- `pix_ready` is registered from state. It rises on the cycle after the `start` edge and falls on the cycle after the last-pixel acceptance edge.
- Window latency: 1 cycle. On the acceptance edge, `win_pix`, `win_row`, `win_col` and `win_valid` register, so `win_valid` is high for the cycle after acceptance only.
- `win_valid` is 0 in every cycle without a qualifying acceptance. `win_pix`, `win_row` and `win_col` hold their last values while `win_valid`=0.
- Maximum throughput: one window per cycle with no input bubbles. The block has no backpressure from the PE chain.
- `frame_done` goes high the cycle after the edge that counts the final `res_valid`. If the final result arrives before the last pixel is accepted, `frame_done` goes high the cycle after entering DRAIN.
- `busy` is high from the cycle after `start` through the DONE cycle inclusive.

## Test plan
- 4x4 frame, pixels 0..15, continuous `pix_valid`, `res_valid` = `win_valid` delayed 3 cycles:
  - 4 windows at (1,1), (1,2), (2,1), (2,2);
  - first window `win_pix` bytes i-major = {0,1,2,4,5,6,8,9,10};
  - `frame_done` 1 cycle after the 4th `res_valid`, then `busy`=0.
- Same frame with `pix_valid` toggling every other cycle: identical windows and values; `win_valid` never on consecutive cycles.
- 3x3 minimum frame, pixels 10..18: exactly one window {10..18} at (1,1); `pix_ready` drops after the 9th acceptance.
- `start` pulsed mid-STREAM and in the DONE cycle: no effect on counters or state; the next `start` in IDLE begins a fresh frame with `row`=`col`=0.
- `rst` asserted after 7 pixels of a 4x4 frame, plus 2 stray `res_valid` pulses afterwards: all outputs go to reset values, stays IDLE, no `frame_done`; a following clean frame matches the first scenario.
- 4x4 frame with 6 `res_valid` pulses: `frame_done` on the 4th result only; pulses 5 and 6 are ignored.
